// File: rtl/pci_fifo_arbiter_p.sv
// pci_fifo_arbiter_p
//   First-come-first-served PCI arbiter for NUM_REQ masters with active-low
//   REQ#/GNT#. Falling REQ edges are queued in a circular order FIFO. The
//   arbiter also supports a grant timeout, request withdrawal, hidden
//   (back-to-back) arbitration and optional bus parking.
// Ports
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   REQ          per-master bus request, active low
//   FRAME, IRDY  shared PCI FRAME#/IRDY#, active low
//   GNT          registered grants, active low, at most one bit low
//   owner_id     master currently granted / owning the bus
//   owner_valid  owner_id is meaningful
//   q_count      entries in the order queue (stale ones included)
//   timeout      one-clock pulse when the timer revokes a grant
module pci_fifo_arbiter_p #(
  parameter int NUM_REQ     = 8,
  parameter int GNT_TIMEOUT = 16,
  parameter int HIDDEN_ARB  = 1,
  parameter int PARK_EN     = 0,
  parameter int PARK_ID     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic                       FRAME,
  input  logic                       IRDY,
  output logic [NUM_REQ-1:0]         GNT,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       owner_valid,
  output logic [$clog2(NUM_REQ):0]   q_count,
  output logic                       timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(GNT_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY} state_t;

  state_t               state;
  logic [IW-1:0]        queue [NUM_REQ];
  logic [IW-1:0]        rd_ptr, wr_ptr;
  logic [NUM_REQ-1:0]   req_q, pending, push;
  logic [IW-1:0]        slot [NUM_REQ];
  logic [CW-1:0]        push_cnt;
  logic [IW-1:0]        head;
  logic                 head_valid, head_stale;
  logic                 bus_idle, idle_q, parked;
  logic                 grant_ok, hidden_ok, pop;
  logic [TW-1:0]        timer;

  // Pointer advance modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {2'b00, p} + {1'b0, n};
    if (s >= (CW+1)'(NUM_REQ)) s = s - (CW+1)'(NUM_REQ);
    return s[IW-1:0];
  endfunction

  assign bus_idle   = FRAME & IRDY;
  assign head       = queue[rd_ptr];
  assign head_valid = (q_count != '0) &&  pending[head];
  assign head_stale = (q_count != '0) && !pending[head];

  // Same-cycle edges take consecutive slots in ascending index order.
  always_comb begin
    logic [CW-1:0] cnt;
    cnt  = '0;
    push = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot[i] = wrap_add(wr_ptr, cnt);
      if (req_q[i] && !REQ[i] && !pending[i] &&
          !(owner_valid && owner_id == IW'(i)) &&
          (q_count + cnt < CW'(NUM_REQ))) begin
        push[i] = 1'b1;
        cnt     = cnt + 1'b1;
      end
    end
    push_cnt = cnt;
  end

  // Leaving the parked master for someone else costs a turnaround clock
  // first, so no grant is issued in that cycle.
  assign grant_ok  = (state == IDLE) && head_valid &&
                     !(parked && !FRAME && idle_q) &&
                     !(parked && head != IW'(PARK_ID));
  assign hidden_ok = (HIDDEN_ARB != 0) && (state == BUSY) && FRAME && !IRDY && head_valid;
  // Stale heads are dropped as soon as they surface.
  assign pop       = head_stale || grant_ok || hidden_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      GNT         <= '1;
      owner_id    <= '0;
      owner_valid <= 1'b0;
      q_count     <= '0;
      timeout     <= 1'b0;
      req_q       <= '1;
      pending     <= '0;
      timer       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      idle_q      <= 1'b0;
      parked      <= 1'b0;
    end else begin
      req_q   <= REQ;
      idle_q  <= bus_idle;
      timeout <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) begin
          queue[slot[i]] <= IW'(i);
          pending[i]     <= 1'b1;
        end else if (REQ[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_ok || hidden_ok) pending[head] <= 1'b0;
      wr_ptr  <= wrap_add(wr_ptr, push_cnt);
      if (pop) rd_ptr <= wrap_add(rd_ptr, CW'(1));
      q_count <= q_count + push_cnt - CW'(pop);

      case (state)
        IDLE: begin
          if (parked && !FRAME && idle_q) begin
            state <= BUSY;
          end else if (head_valid) begin
            if (grant_ok) begin
              GNT         <= ~(NUM_REQ'(1) << head);
              owner_id    <= head;
              owner_valid <= 1'b1;
              parked      <= 1'b0;
              timer       <= '0;
              state       <= GRANTED;
            end else begin
              GNT         <= '1;
              owner_valid <= 1'b0;
              parked      <= 1'b0;
            end
          end else if (PARK_EN != 0 && !parked && q_count == '0 && bus_idle) begin
            GNT         <= ~(NUM_REQ'(1) << PARK_ID);
            owner_id    <= IW'(PARK_ID);
            owner_valid <= 1'b1;
            parked      <= 1'b1;
          end
        end
        GRANTED: begin
          // Also completes a hidden grant whose turnaround clock just ended.
          GNT <= ~(NUM_REQ'(1) << owner_id);
          if (!FRAME && idle_q) begin
            state <= BUSY;
          end else if (REQ[owner_id]) begin
            GNT         <= '1;
            owner_valid <= 1'b0;
            state       <= IDLE;
          end else if (bus_idle) begin
            if (timer == TW'(GNT_TIMEOUT - 1)) begin
              GNT         <= '1;
              owner_valid <= 1'b0;
              timeout     <= 1'b1;
              state       <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        BUSY: begin
          if (FRAME) begin
            GNT <= '1;
            if (!IRDY) begin
              // Final data phase: hand the next grant over while the
              // current master finishes; GNT stays high this clock.
              if (hidden_ok) begin
                owner_id    <= head;
                owner_valid <= 1'b1;
                parked      <= 1'b0;
                timer       <= '0;
                state       <= GRANTED;
              end
            end else begin
              owner_valid <= 1'b0;
              parked      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pci_fifo_arbiter_p.sv
module tb_pci_fifo_arbiter_p;
  logic       clk = 1'b0;
  logic       rst_n, frame, irdy;
  logic [7:0] req, gnt;
  logic [2:0] oid;
  logic       ov, to;
  logic [3:0] qc;

  logic       rst_p, frame_p, irdy_p;
  logic [7:0] req_p, gnt_p;
  logic [2:0] oid_p;
  logic       ov_p, to_p;
  logic [3:0] qc_p;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pci_fifo_arbiter_p #(.NUM_REQ(8), .GNT_TIMEOUT(16), .HIDDEN_ARB(1), .PARK_EN(0), .PARK_ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .REQ(req), .FRAME(frame), .IRDY(irdy),
    .GNT(gnt), .owner_id(oid), .owner_valid(ov), .q_count(qc), .timeout(to));

  pci_fifo_arbiter_p #(.NUM_REQ(8), .GNT_TIMEOUT(16), .HIDDEN_ARB(1), .PARK_EN(1), .PARK_ID(2)) dut_p (
    .clk(clk), .rst_n(rst_p), .REQ(req_p), .FRAME(frame_p), .IRDY(irdy_p),
    .GNT(gnt_p), .owner_id(oid_p), .owner_valid(ov_p), .q_count(qc_p), .timeout(to_p));

  typedef struct {
    string      name;
    bit         park;
    bit         rst;
    logic [7:0] req;
    bit         fr, ir;
    logic [7:0] gnt;
    int         id;
    bit         ov;
    int         qc;
    bit         to;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t V(string name, bit park, bit rst, logic [7:0] r, bit fr, bit ir,
                             logic [7:0] g, int id, bit o, int q, bit t);
    vec_t v;
    v.name = name; v.park = park; v.rst = rst; v.req = r; v.fr = fr; v.ir = ir;
    v.gnt = g; v.id = id; v.ov = o; v.qc = q; v.to = t;
    return v;
  endfunction

  // Drive one clock of inputs, queue the expected post-edge outputs, then
  // pop and compare once the DUT has produced them.
  task automatic step(input vec_t v);
    vec_t e;
    logic [7:0] g; logic [2:0] id; logic o, t; logic [3:0] q;
    if (v.park) begin rst_p = v.rst; req_p = v.req; frame_p = v.fr; irdy_p = v.ir; end
    else        begin rst_n = v.rst; req   = v.req; frame   = v.fr; irdy   = v.ir; end
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    if (e.park) begin g = gnt_p; id = oid_p; o = ov_p; q = qc_p; t = to_p; end
    else        begin g = gnt;   id = oid;   o = ov;   q = qc;   t = to;   end
    n_cmp++;
    if (g !== e.gnt || o !== e.ov || (e.ov && id !== 3'(e.id)) || q !== 4'(e.qc) || t !== e.to) begin
      n_err++;
      $display("FAIL %s: got gnt=%h ov=%b id=%0d qc=%0d to=%b, want gnt=%h ov=%b id=%0d qc=%0d to=%b",
               e.name, g, o, id, q, t, e.gnt, e.ov, e.id, e.qc, e.to);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 8'hFF; frame = 1'b1; irdy = 1'b1;
    rst_p = 1'b0; req_p = 8'hFF; frame_p = 1'b1; irdy_p = 1'b1;

    // name, park, rst, REQ, FRAME, IRDY | GNT, id, ov, q_count, timeout
    tbl.push_back(V("reset0",   0, 0, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(V("reset1",   0, 0, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    // single request, transaction, release
    tbl.push_back(V("r3_push",  0, 1, 8'hF7, 1, 1, 8'hFF, 0, 0, 1, 0));
    tbl.push_back(V("r3_gnt",   0, 1, 8'hF7, 1, 1, 8'hF7, 3, 1, 0, 0));
    tbl.push_back(V("r3_frame", 0, 1, 8'hF7, 0, 1, 8'hF7, 3, 1, 0, 0));
    tbl.push_back(V("r3_data",  0, 1, 8'hFF, 0, 0, 8'hF7, 3, 1, 0, 0));
    tbl.push_back(V("r3_final", 0, 1, 8'hFF, 1, 0, 8'hFF, 3, 1, 0, 0));
    tbl.push_back(V("r3_idle",  0, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    // FCFS order 2,5,6
    tbl.push_back(V("o_push25", 0, 1, 8'hDB, 1, 1, 8'hFF, 0, 0, 2, 0));
    tbl.push_back(V("o_gnt2",   0, 1, 8'h9B, 1, 1, 8'hFB, 2, 1, 2, 0));
    tbl.push_back(V("o_busy2",  0, 1, 8'h9B, 0, 1, 8'hFB, 2, 1, 2, 0));
    tbl.push_back(V("o_hid5",   0, 1, 8'h9F, 1, 0, 8'hFF, 5, 1, 1, 0));
    tbl.push_back(V("o_gnt5",   0, 1, 8'h9F, 1, 1, 8'hDF, 5, 1, 1, 0));
    tbl.push_back(V("o_busy5",  0, 1, 8'h9F, 0, 1, 8'hDF, 5, 1, 1, 0));
    tbl.push_back(V("o_end5",   0, 1, 8'hBF, 1, 1, 8'hFF, 0, 0, 1, 0));
    tbl.push_back(V("o_gnt6",   0, 1, 8'hBF, 1, 1, 8'hBF, 6, 1, 0, 0));
    tbl.push_back(V("o_hold6",  0, 1, 8'hBF, 1, 1, 8'hBF, 6, 1, 0, 0));
    tbl.push_back(V("o_wdraw6", 0, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    // stale entry for master 4
    tbl.push_back(V("s_push0",  0, 1, 8'hFE, 1, 1, 8'hFF, 0, 0, 1, 0));
    tbl.push_back(V("s_push4",  0, 1, 8'hEE, 1, 1, 8'hFE, 0, 1, 1, 0));
    tbl.push_back(V("s_rel4",   0, 1, 8'hFE, 1, 1, 8'hFE, 0, 1, 1, 0));
    tbl.push_back(V("s_drop4",  0, 1, 8'hFE, 1, 1, 8'hFE, 0, 1, 0, 0));
    tbl.push_back(V("s_busy0",  0, 1, 8'hFE, 0, 1, 8'hFE, 0, 1, 0, 0));
    tbl.push_back(V("s_end0",   0, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(V("s_quiet",  0, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    // hidden arbitration 0 -> 7
    tbl.push_back(V("h_push0",  0, 1, 8'hFE, 1, 1, 8'hFF, 0, 0, 1, 0));
    tbl.push_back(V("h_gnt0",   0, 1, 8'hFE, 1, 1, 8'hFE, 0, 1, 0, 0));
    tbl.push_back(V("h_busy0",  0, 1, 8'hFE, 0, 1, 8'hFE, 0, 1, 0, 0));
    tbl.push_back(V("h_push7",  0, 1, 8'h7E, 0, 0, 8'hFE, 0, 1, 1, 0));
    tbl.push_back(V("h_final",  0, 1, 8'h7F, 1, 0, 8'hFF, 7, 1, 0, 0));
    tbl.push_back(V("h_gnt7",   0, 1, 8'h7F, 1, 0, 8'h7F, 7, 1, 0, 0));
    tbl.push_back(V("h_idle",   0, 1, 8'h7F, 1, 1, 8'h7F, 7, 1, 0, 0));
    tbl.push_back(V("h_busy7",  0, 1, 8'h7F, 0, 1, 8'h7F, 7, 1, 0, 0));
    tbl.push_back(V("h_hold7",  0, 1, 8'hFF, 0, 0, 8'h7F, 7, 1, 0, 0));
    tbl.push_back(V("h_end7",   0, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));

    foreach (tbl[k]) step(tbl[k]);

    // Grant timeout: master 1 never drives FRAME, master 0 waits behind it.
    step(V("t_push1", 0, 1, 8'hFD, 1, 1, 8'hFF, 0, 0, 1, 0));
    step(V("t_gnt1",  0, 1, 8'hFC, 1, 1, 8'hFD, 1, 1, 1, 0));
    for (int c = 1; c < 16; c++)
      step(V($sformatf("t_wait%0d", c), 0, 1, 8'hFC, 1, 1, 8'hFD, 1, 1, 1, 0));
    step(V("t_revoke", 0, 1, 8'hFC, 1, 1, 8'hFF, 0, 0, 1, 1));
    step(V("t_gnt0",   0, 1, 8'hFC, 1, 1, 8'hFE, 0, 1, 0, 0));
    step(V("t_wdraw0", 0, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));

    // Parking on master 2, unpark turnaround, reset mid-BUSY.
    step(V("p_reset",  1, 0, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    step(V("p_park",   1, 1, 8'hFF, 1, 1, 8'hFB, 2, 1, 0, 0));
    step(V("p_push5",  1, 1, 8'hDF, 1, 1, 8'hFB, 2, 1, 1, 0));
    step(V("p_unpark", 1, 1, 8'hDF, 1, 1, 8'hFF, 0, 0, 1, 0));
    step(V("p_gnt5",   1, 1, 8'hDF, 1, 1, 8'hDF, 5, 1, 0, 0));
    step(V("p_wdraw5", 1, 1, 8'hFF, 1, 1, 8'hFF, 0, 0, 0, 0));
    step(V("p_repark", 1, 1, 8'hFF, 1, 1, 8'hFB, 2, 1, 0, 0));
    step(V("p_busy2",  1, 1, 8'hFF, 0, 1, 8'hFB, 2, 1, 0, 0));
    step(V("p_push6",  1, 1, 8'hBF, 0, 0, 8'hFB, 2, 1, 1, 0));
    step(V("p_rstmid", 1, 0, 8'hBF, 0, 0, 8'hFF, 0, 0, 0, 0));
    step(V("p_after",  1, 1, 8'hFF, 1, 1, 8'hFB, 2, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
